serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Parametrised multi-cycle adder; successor to the combinational half adder.
//  Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
//  Adds BPC bits per clock with a registered carry, so WIDTH/BPC cycles per add.
//  Returns Sum/Carry over a second valid/ready handshake; used where area beats latency.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits, >=1
//  BPC    1  bits added per cycle; must divide WIDTH (elaboration error otherwise)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands A, B, Cin valid
//  in_ready   out  1      block can accept operands
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in into bit 0
//  out_valid  out  1      Sum/Carry hold a completed result
//  out_ready  in   1      consumer accepts result
//  Sum        out  WIDTH  (A+B+Cin) mod 2^WIDTH
//  Carry      out  1      carry out of bit WIDTH-1
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0,
//    busy=0, Sum=0, Carry=0, counter=0, carry flop=0, operand shifters=0.
//  - FSM: IDLE -> RUN on in_valid&in_ready; RUN -> DONE after N=WIDTH/BPC RUN
//    cycles; DONE -> IDLE on out_valid&out_ready. No other transitions.
//  - in_ready = (state==IDLE), combinational from state only. No overlap of
//    a new operation with an unconsumed result.
//  - Accept edge: latch A, B into shift regs, carry flop<=Cin, counter<=0.
//  - Each RUN cycle: add low BPC bits of A_sh, B_sh and carry flop; shift
//    result BPC bits into sum shifter from MSB side; carry flop<=slice carry-out;
//    shift A_sh/B_sh right by BPC; counter++.
//  - Last RUN cycle (counter==N-1): Sum<=full sum, Carry<=final carry, go DONE.
//  - Latency: operands accepted at edge k -> out_valid high after edge k+N.
//  - Sum/Carry change only on the completion edge; stable while out_valid=1 and
//    retained after handoff until next completion.
//  - out_valid held high with Sum/Carry stable until out_ready; back-to-back:
//    out handshake at edge m -> in_ready=1 after edge m; next accept at m+1 earliest.
//  - in_valid in RUN/DONE ignored; operand inputs sampled only on accept edge.
//  - out_ready while out_valid=0 has no effect.
//  - rst_n low mid-RUN or mid-DONE: operation aborted, reset values at once;
//    no result is ever produced for the aborted operands.
//  - Overflow wraps mod 2^WIDTH; Carry is the sole overflow indicator.
//  - BPC==WIDTH: N=1; single RUN cycle; must still use the full handshake.
// TESTING
//  1 WIDTH=8,BPC=1: A=0x00,B=0x00,Cin=0 -> Sum=0x00,Carry=0; out_valid exactly
//    8 edges after accept; busy high throughout.
//  2 WIDTH=8,BPC=1: A=0xFF,B=0x01,Cin=0 -> Sum=0x00,Carry=1; A=0xA5,B=0x5A,
//    Cin=1 -> Sum=0x00,Carry=1; A=0x3C,B=0x42,Cin=0 -> Sum=0x7E,Carry=0.
//  3 Backpressure: out_ready low 5 cycles after out_valid -> Sum/Carry stable,
//    in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
//  4 Reset mid-op: assert rst_n=0 at RUN counter=3 -> all outputs 0 immediately;
//    after release, A=0x01,B=0x01 -> Sum=0x02, no stale result seen.
//  5 WIDTH=8,BPC=4: A=0x99,B=0x77,Cin=0 -> Sum=0x10,Carry=1 after 2 RUN cycles;
//    WIDTH=1,BPC=1: all 8 (A,B,Cin) combos match full-adder truth table.
//  6 Random: 1000 ops, WIDTH=16,BPC in {1,2,4,16}, random in_valid/out_ready ->
//    every result matches A+B+Cin reference model, order preserved, none lost.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial (BPC bits per clock) adder with valid/ready handshakes on operands and result.
// A WIDTH-bit add takes WIDTH/BPC RUN cycles, and the carry is held in a flop between slices.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             busy
);

  localparam int unsigned N     = (BPC == 0) ? 1 : WIDTH / BPC;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW    = BPC + 1;

  generate
    if (BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bpc_check
      $error("serial_adder: BPC must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [SW-1:0]      slice;
  logic [WIDTH-1:0]   sum_sh_next;

  // One BPC-wide slice of the add; its result enters the sum shifter from the MSB side.
  always_comb begin
    slice       = {1'b0, a_sh_q[BPC-1:0]} + {1'b0, b_sh_q[BPC-1:0]} + SW'(carry_q);
    sum_sh_next = (sum_sh_q >> BPC) | (WIDTH'(slice[BPC-1:0]) << (WIDTH - BPC));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> BPC;
        b_sh_d   = b_sh_q >> BPC;
        sum_sh_d = sum_sh_next;
        carry_d  = slice[BPC];
        cnt_d    = cnt_q + CNT_W'(1);
        // Result registers only move on the completion edge.
        if (cnt_q == CNT_W'(N - 1)) begin
          sum_d   = sum_sh_next;
          cout_d  = slice[BPC];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign Sum       = sum_q;
  assign Carry     = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder for several WIDTH/BPC configurations.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8, BPC=1
  logic       i8_in_valid, i8_in_ready, i8_cin, i8_out_valid, i8_out_ready, i8_carry, i8_busy;
  logic [7:0] i8_a, i8_b, i8_sum;
  // WIDTH=8, BPC=4
  logic       i84_in_valid, i84_in_ready, i84_cin, i84_out_valid, i84_out_ready, i84_carry, i84_busy;
  logic [7:0] i84_a, i84_b, i84_sum;
  // WIDTH=1, BPC=1
  logic       i1_in_valid, i1_in_ready, i1_cin, i1_out_valid, i1_out_ready, i1_busy;
  logic [0:0] i1_a, i1_b, i1_sum;
  logic       i1_carry;
  // WIDTH=16, BPC=4
  logic        i16_in_valid, i16_in_ready, i16_cin, i16_out_valid, i16_out_ready, i16_carry, i16_busy;
  logic [15:0] i16_a, i16_b, i16_sum;

  serial_adder #(.WIDTH(8), .BPC(1)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(i8_in_valid), .in_ready(i8_in_ready),
    .A(i8_a), .B(i8_b), .Cin(i8_cin), .out_valid(i8_out_valid), .out_ready(i8_out_ready),
    .Sum(i8_sum), .Carry(i8_carry), .busy(i8_busy));

  serial_adder #(.WIDTH(8), .BPC(4)) u_d84 (
    .clk(clk), .rst_n(rst_n), .in_valid(i84_in_valid), .in_ready(i84_in_ready),
    .A(i84_a), .B(i84_b), .Cin(i84_cin), .out_valid(i84_out_valid), .out_ready(i84_out_ready),
    .Sum(i84_sum), .Carry(i84_carry), .busy(i84_busy));

  serial_adder #(.WIDTH(1), .BPC(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(i1_in_valid), .in_ready(i1_in_ready),
    .A(i1_a), .B(i1_b), .Cin(i1_cin), .out_valid(i1_out_valid), .out_ready(i1_out_ready),
    .Sum(i1_sum), .Carry(i1_carry), .busy(i1_busy));

  serial_adder #(.WIDTH(16), .BPC(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(i16_in_valid), .in_ready(i16_in_ready),
    .A(i16_a), .B(i16_b), .Cin(i16_cin), .out_valid(i16_out_valid), .out_ready(i16_out_ready),
    .Sum(i16_sum), .Carry(i16_carry), .busy(i16_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stimulus drivers: one full transaction; lat = edges from accept to out_valid, -1 on timeout.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output logic [7:0] s, output logic c, output int lat);
    int n;
    lat = -1;
    i8_a = a; i8_b = b; i8_cin = cin; i8_in_valid = 1'b1; i8_out_ready = 1'b0;
    n = 0;
    while (!i8_in_ready && n < 50) begin tick(); n++; end
    tick();
    i8_in_valid = 1'b0;
    n = 0;
    while (!i8_out_valid && n < 50) begin tick(); n++; end
    if (i8_out_valid) lat = n;
    s = i8_sum; c = i8_carry;
    i8_out_ready = 1'b1;
    tick();
    i8_out_ready = 1'b0;
  endtask

  task automatic run84(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] s, output logic c, output int lat);
    int n;
    lat = -1;
    i84_a = a; i84_b = b; i84_cin = cin; i84_in_valid = 1'b1; i84_out_ready = 1'b0;
    n = 0;
    while (!i84_in_ready && n < 50) begin tick(); n++; end
    tick();
    i84_in_valid = 1'b0;
    n = 0;
    while (!i84_out_valid && n < 50) begin tick(); n++; end
    if (i84_out_valid) lat = n;
    s = i84_sum; c = i84_carry;
    i84_out_ready = 1'b1;
    tick();
    i84_out_ready = 1'b0;
  endtask

  task automatic run1(input logic a, input logic b, input logic cin,
                      output logic s, output logic c, output int lat);
    int n;
    lat = -1;
    i1_a = a; i1_b = b; i1_cin = cin; i1_in_valid = 1'b1; i1_out_ready = 1'b0;
    n = 0;
    while (!i1_in_ready && n < 50) begin tick(); n++; end
    tick();
    i1_in_valid = 1'b0;
    n = 0;
    while (!i1_out_valid && n < 50) begin tick(); n++; end
    if (i1_out_valid) lat = n;
    s = i1_sum[0]; c = i1_carry;
    i1_out_ready = 1'b1;
    tick();
    i1_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total++; if (i8_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", i8_in_ready); end
    total++; if (i8_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", i8_out_valid); end
    total++; if (i8_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", i8_busy); end
    total++; if (i8_sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", i8_sum); end
    total++; if (i8_carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", i8_carry); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero;
    i8_a = 8'h00; i8_b = 8'h00; i8_cin = 1'b0; i8_in_valid = 1'b1;
    total++; if (i8_in_ready !== 1'b1) begin bad++; $display("FAIL zero_in_ready got=%b exp=1", i8_in_ready); end
    tick();
    i8_in_valid = 1'b0;
    total++; if (i8_busy !== 1'b1) begin bad++; $display("FAIL zero_busy_accept got=%b exp=1", i8_busy); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (i8_out_valid !== (i == 8)) begin
        bad++; $display("FAIL zero_latency edge=%0d out_valid got=%b exp=%b", i, i8_out_valid, (i == 8));
      end
      total++; if (i8_busy !== 1'b1) begin bad++; $display("FAIL zero_busy edge=%0d got=%b exp=1", i, i8_busy); end
    end
    total++; if (i8_sum !== 8'h00) begin bad++; $display("FAIL zero_sum got=%h exp=00", i8_sum); end
    total++; if (i8_carry !== 1'b0) begin bad++; $display("FAIL zero_carry got=%b exp=0", i8_carry); end
    i8_out_ready = 1'b1;
    tick();
    i8_out_ready = 1'b0;
    total++; if (i8_in_ready !== 1'b1) begin bad++; $display("FAIL zero_handoff_in_ready got=%b exp=1", i8_in_ready); end
    total++; if (i8_busy !== 1'b0) begin bad++; $display("FAIL zero_handoff_busy got=%b exp=0", i8_busy); end
  endtask

  task automatic test_vectors;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    logic [7:0] es [3];
    logic       ec [3];
    logic [7:0] s;
    logic       c;
    int         lat;
    va = '{8'hFF, 8'hA5, 8'h3C};
    vb = '{8'h01, 8'h5A, 8'h42};
    vc = '{1'b0,  1'b1,  1'b0};
    es = '{8'h00, 8'h00, 8'h7E};
    ec = '{1'b1,  1'b1,  1'b0};
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], vc[i], s, c, lat);
      total++; if (s !== es[i]) begin bad++; $display("FAIL vec%0d_sum got=%h exp=%h", i, s, es[i]); end
      total++; if (c !== ec[i]) begin bad++; $display("FAIL vec%0d_carry got=%b exp=%b", i, c, ec[i]); end
      total++; if (lat !== 8) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=8", i, lat); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    i8_a = 8'h3C; i8_b = 8'h42; i8_cin = 1'b0; i8_in_valid = 1'b1; i8_out_ready = 1'b0;
    tick();
    i8_in_valid = 1'b0;
    n = 0;
    while (!i8_out_valid && n < 50) begin tick(); n++; end
    total++; if (i8_out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout out_valid got=%b exp=1", i8_out_valid); end
    for (int i = 0; i < 5; i++) begin
      i8_in_valid = i[0] ? 1'b0 : 1'b1;
      i8_a = 8'hFF; i8_b = 8'hFF; i8_cin = 1'b1;
      tick();
      total++; if (i8_sum !== 8'h7E) begin bad++; $display("FAIL bp_sum cyc=%0d got=%h exp=7e", i, i8_sum); end
      total++; if (i8_carry !== 1'b0) begin bad++; $display("FAIL bp_carry cyc=%0d got=%b exp=0", i, i8_carry); end
      total++; if (i8_out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, i8_out_valid); end
      total++; if (i8_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, i8_in_ready); end
    end
    i8_in_valid = 1'b0;
    i8_out_ready = 1'b1;
    tick();
    total++; if (i8_out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", i8_out_valid); end
    total++; if (i8_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", i8_in_ready); end
    total++; if (i8_sum !== 8'h7E) begin bad++; $display("FAIL bp_retained_sum got=%h exp=7e", i8_sum); end
    // out_ready held in IDLE must not disturb anything
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (i8_busy !== 1'b0 || i8_out_valid !== 1'b0) begin
        bad++; $display("FAIL bp_idle_stray busy=%b out_valid=%b exp=0/0", i8_busy, i8_out_valid);
      end
    end
    i8_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] s;
    logic       c;
    int         lat;
    logic       stale;
    i8_a = 8'h55; i8_b = 8'h0F; i8_cin = 1'b1; i8_in_valid = 1'b1;
    tick();
    i8_in_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (i8_busy !== 1'b1) begin bad++; $display("FAIL rm_busy_before got=%b exp=1", i8_busy); end
    rst_n = 1'b0;
    #1;
    total++; if (i8_in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%b exp=1", i8_in_ready); end
    total++; if (i8_out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b exp=0", i8_out_valid); end
    total++; if (i8_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", i8_busy); end
    total++; if (i8_sum !== 8'h00) begin bad++; $display("FAIL rm_sum got=%h exp=00", i8_sum); end
    total++; if (i8_carry !== 1'b0) begin bad++; $display("FAIL rm_carry got=%b exp=0", i8_carry); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i8_out_valid !== 1'b0 || i8_busy !== 1'b0) stale = 1'b1;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL rm_stale_result got=%b exp=0", stale); end
    run8(8'h01, 8'h01, 1'b0, s, c, lat);
    total++; if (s !== 8'h02) begin bad++; $display("FAIL rm_after_sum got=%h exp=02", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL rm_after_carry got=%b exp=0", c); end
    total++; if (lat !== 8) begin bad++; $display("FAIL rm_after_latency got=%0d exp=8", lat); end
  endtask

  task automatic test_bpc4;
    logic [7:0] s;
    logic       c;
    int         lat;
    run84(8'h99, 8'h77, 1'b0, s, c, lat);
    total++; if (s !== 8'h10) begin bad++; $display("FAIL bpc4_a_sum got=%h exp=10", s); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL bpc4_a_carry got=%b exp=1", c); end
    total++; if (lat !== 2) begin bad++; $display("FAIL bpc4_a_latency got=%0d exp=2", lat); end
    run84(8'h0F, 8'h01, 1'b1, s, c, lat);
    total++; if (s !== 8'h11) begin bad++; $display("FAIL bpc4_b_sum got=%h exp=11", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL bpc4_b_carry got=%b exp=0", c); end
  endtask

  task automatic test_width1;
    logic s, c, es, ec;
    int   lat;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      es = v[2] ^ v[1] ^ v[0];
      ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      run1(v[2], v[1], v[0], s, c, lat);
      total++; if (s !== es) begin bad++; $display("FAIL w1_sum abc=%b got=%b exp=%b", v, s, es); end
      total++; if (c !== ec) begin bad++; $display("FAIL w1_carry abc=%b got=%b exp=%b", v, c, ec); end
      total++; if (lat !== 1) begin bad++; $display("FAIL w1_latency abc=%b got=%0d exp=1", v, lat); end
    end
  endtask

  task automatic test_random;
    logic [16:0] q [$];
    logic [16:0] exp_v;
    logic [16:0] got_v;
    int          sent;
    int          recv;
    int          cyc;
    logic        fire_in;
    logic        fire_out;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 40000) begin
      i16_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      i16_a         = 16'($urandom);
      i16_b         = 16'($urandom);
      i16_cin       = 1'($urandom);
      i16_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fire_in  = i16_in_valid && i16_in_ready;
      fire_out = i16_out_valid && i16_out_ready;
      if (fire_in) begin
        q.push_back({1'b0, i16_a} + {1'b0, i16_b} + 17'(i16_cin));
        sent++;
      end
      if (fire_out) begin
        got_v = {i16_carry, i16_sum};
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected_result got=%h exp=none", got_v);
        end else begin
          exp_v = q.pop_front();
          if (got_v !== exp_v) begin
            bad++; $display("FAIL rnd_result op=%0d got=%h exp=%h", recv, got_v, exp_v);
          end
        end
        recv++;
      end
      tick();
      cyc++;
    end
    i16_in_valid = 1'b0;
    i16_out_ready = 1'b0;
    total++;
    if (recv != 1000 || q.size() != 0) begin
      bad++; $display("FAIL rnd_count got=%0d pending=%0d exp=1000/0", recv, q.size());
    end
  endtask

  initial begin
    total = 0; bad = 0;
    i8_in_valid = 1'b0; i8_out_ready = 1'b0; i8_a = '0; i8_b = '0; i8_cin = 1'b0;
    i84_in_valid = 1'b0; i84_out_ready = 1'b0; i84_a = '0; i84_b = '0; i84_cin = 1'b0;
    i1_in_valid = 1'b0; i1_out_ready = 1'b0; i1_a = '0; i1_b = '0; i1_cin = 1'b0;
    i16_in_valid = 1'b0; i16_out_ready = 1'b0; i16_a = '0; i16_b = '0; i16_cin = 1'b0;
    test_reset();
    test_zero();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_bpc4();
    test_width1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
